accum_wr_ctrl: RTL and testbench

- Output-side counterpart of the input read controller: collects the skewed per-column partial sums leaving the systolic array and writes them into an internal accumulator store.
- Each column is written in overwrite or accumulate (read-add-write) mode. A drain read port returns stored results.
- Signals `wr_done` to the control side once every column has written `num_row` results.
- Sits between the systolic array's `psum_out`/`en_out` and the control/drain logic.

---
 rtl/accum_wr_ctrl.sv | 156 +++++++++++++++
 tb/tb_accum_wr_ctrl.sv | 246 ++++++++++++++++++++++++
 2 files changed

// File: rtl/accum_wr_ctrl.sv
// accum_wr_ctrl
//   Collects the skewed per-column partial sums leaving the systolic array and
//   writes them into one accumulator bank per column, either overwriting the
//   stored row or adding to it. A drain port reads one row across all banks.
//   The control side sees wr_done once every column has written num_row rows.
//
// Ports
//   clk, rstn          clock (rising edge), asynchronous active-low reset
//   start              one-cycle pulse; latches base_addr, num_row, accum_mode
//   base_addr          first accumulator row of the tile
//   num_row            results expected per column
//   accum_mode         0 = overwrite, 1 = add to stored value
//   en_in / psum_in    per-column valid and partial sum from the array
//   rd_en / rd_addr    drain read request and row
//   rd_data / rd_valid drain read data (one cycle after rd_en) and its valid
//   busy               tile in progress (BUSY or DONE)
//   wr_done            one-cycle completion pulse
module accum_wr_ctrl #(
    parameter int SYS_COL    = 4,
    parameter int DATA_WIDTH = 16,
    parameter int ACCUM_SIZE = 1024,
    localparam int PSUM_WIDTH = 2 * DATA_WIDTH,
    localparam int AW         = $clog2(ACCUM_SIZE)
) (
    input  logic                         clk,
    input  logic                         rstn,
    input  logic                         start,
    input  logic [AW-1:0]                base_addr,
    input  logic [DATA_WIDTH-1:0]        num_row,
    input  logic                         accum_mode,
    input  logic [SYS_COL-1:0]           en_in,
    input  logic signed [PSUM_WIDTH-1:0] psum_in [0:SYS_COL-1],
    input  logic                         rd_en,
    input  logic [AW-1:0]                rd_addr,
    output logic signed [PSUM_WIDTH-1:0] rd_data [0:SYS_COL-1],
    output logic                         rd_valid,
    output logic                         busy,
    output logic                         wr_done
);

    localparam logic [DATA_WIDTH-1:0] CNT_ONE = DATA_WIDTH'(1);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;

    state_t                  state_q, state_d;
    logic [AW-1:0]           base_q;
    logic [DATA_WIDTH-1:0]   num_row_q;
    logic                    mode_q;
    logic [DATA_WIDTH-1:0]   cnt_q [SYS_COL];
    logic [SYS_COL-1:0]      done_q;
    logic [SYS_COL-1:0]      wr_fire;
    logic [SYS_COL-1:0]      done_set;

    // Accumulation wraps modulo 2^PSUM_WIDTH; no saturation.
    function automatic logic signed [PSUM_WIDTH-1:0] wrap_add(
        input logic signed [PSUM_WIDTH-1:0] a,
        input logic signed [PSUM_WIDTH-1:0] b
    );
        return a + b;
    endfunction

    // A start edge (fresh or restart) takes priority over column writes.
    always_comb begin
        wr_fire  = '0;
        done_set = '0;
        for (int c = 0; c < SYS_COL; c++) begin
            wr_fire[c]  = (state_q == BUSY) && !start && en_in[c] && !done_q[c];
            done_set[c] = wr_fire[c] && ((cnt_q[c] + CNT_ONE) == num_row_q);
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (start) state_d = (num_row == '0) ? DONE : BUSY;
            end
            BUSY: begin
                if (start)                            state_d = (num_row == '0) ? DONE : BUSY;
                else if (&(done_q | done_set))        state_d = DONE;
            end
            DONE: begin
                if (start) state_d = (num_row == '0) ? DONE : BUSY;
                else       state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy    = (state_q != IDLE);
    assign wr_done = (state_q == DONE);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            base_q    <= '0;
            num_row_q <= '0;
            mode_q    <= 1'b0;
            done_q    <= '0;
            for (int c = 0; c < SYS_COL; c++) cnt_q[c] <= '0;
        end else if (start) begin
            base_q    <= base_addr;
            num_row_q <= num_row;
            mode_q    <= accum_mode;
            done_q    <= '0;
            for (int c = 0; c < SYS_COL; c++) cnt_q[c] <= '0;
        end else begin
            for (int c = 0; c < SYS_COL; c++) begin
                if (wr_fire[c]) cnt_q[c] <= cnt_q[c] + CNT_ONE;
                if (done_set[c]) done_q[c] <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_valid <= 1'b0;
        end else begin
            rd_valid <= rd_en;
        end
    end

    for (genvar c = 0; c < SYS_COL; c++) begin : g_bank
        logic signed [PSUM_WIDTH-1:0] mem [ACCUM_SIZE];
        logic signed [PSUM_WIDTH-1:0] rd_q;
        logic [AW-1:0]                wr_addr;

        // ACCUM_SIZE is a power of two, so truncating to AW bits is the wrap.
        assign wr_addr = base_q + cnt_q[c][AW-1:0];

        always_ff @(posedge clk) begin
            if (wr_fire[c]) begin
                mem[wr_addr] <= mode_q ? wrap_add(mem[wr_addr], psum_in[c]) : psum_in[c];
            end
        end

        // Same-edge read of a row being written returns the pre-write value.
        always_ff @(posedge clk or negedge rstn) begin
            if (!rstn) begin
                rd_q <= '0;
            end else if (rd_en) begin
                rd_q <= mem[rd_addr];
            end
        end

        assign rd_data[c] = rd_q;
    end

endmodule

// File: tb/tb_accum_wr_ctrl.sv
module tb_accum_wr_ctrl;

    localparam int SC = 4;
    localparam int DW = 16;
    localparam int AS = 1024;
    localparam int PW = 2 * DW;
    localparam int AW = $clog2(AS);

    logic                 clk = 1'b0;
    logic                 rstn;
    logic                 start;
    logic [AW-1:0]        base_addr;
    logic [DW-1:0]        num_row;
    logic                 accum_mode;
    logic [SC-1:0]        en_in;
    logic signed [PW-1:0] psum_in [0:SC-1];
    logic                 rd_en;
    logic [AW-1:0]        rd_addr;
    logic signed [PW-1:0] rd_data [0:SC-1];
    logic                 rd_valid;
    logic                 busy;
    logic                 wr_done;

    always #5 clk = ~clk;

    accum_wr_ctrl #(.SYS_COL(SC), .DATA_WIDTH(DW), .ACCUM_SIZE(AS)) dut (
        .clk(clk), .rstn(rstn), .start(start), .base_addr(base_addr),
        .num_row(num_row), .accum_mode(accum_mode), .en_in(en_in),
        .psum_in(psum_in), .rd_en(rd_en), .rd_addr(rd_addr),
        .rd_data(rd_data), .rd_valid(rd_valid), .busy(busy), .wr_done(wr_done)
    );

    int nvec = 0;
    int nmis = 0;
    int done_pulses = 0;
    logic [PW*SC-1:0] sb_q [$];
    logic [PW-1:0]    model [0:SC-1][0:AS-1];

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        nvec++;
        if (got !== exp) begin
            nmis++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [PW*SC-1:0] pack_row(input int a);
        logic [PW*SC-1:0] r;
        for (int c = 0; c < SC; c++) r[c*PW +: PW] = model[c][a];
        return r;
    endfunction

    function automatic logic [PW-1:0] pval(input int kind, input int c, input int k);
        case (kind)
            0:       return PW'(10 * c + k);
            1:       return PW'(2);
            2:       return 32'hFFFF_FFFF;
            default: return '0;
        endcase
    endfunction

    // Output monitor: wr_done pulse count and scoreboard comparison of reads.
    always @(negedge clk) begin
        logic [PW*SC-1:0] e;
        if (wr_done) done_pulses++;
        if (rd_valid) begin
            if (sb_q.size() == 0) begin
                check_val("rd_valid_unexpected_sb_size", sb_q.size(), 1);
            end else begin
                e = sb_q.pop_front();
                for (int c = 0; c < SC; c++)
                    check_val($sformatf("rd_data_col%0d", c), rd_data[c], e[c*PW +: PW]);
            end
        end
    end

    task automatic do_start(input int base, input int nrow, input int mode);
        start      = 1'b1;
        base_addr  = AW'(base);
        num_row    = DW'(nrow);
        accum_mode = mode[0];
        step();
        start = 1'b0;
    endtask

    // Drives ncyc cycles of skewed column traffic and updates the model.
    task automatic drive(input int base, input int nrow, input int mode, input int kind,
                         input int ncyc, input bit extra, input bit rdw);
        for (int t = 0; t < ncyc; t++) begin
            if (rdw && t == 0) begin
                rd_en   = 1'b1;
                rd_addr = AW'(base);
                sb_q.push_back(pack_row(base));
            end
            for (int c = 0; c < SC; c++) begin
                int k;
                int a;
                k = t - c;
                if (k >= 0 && k < nrow) begin
                    en_in[c]   = 1'b1;
                    psum_in[c] = pval(kind, c, k);
                    a = (base + k) % AS;
                    model[c][a] = mode != 0 ? model[c][a] + pval(kind, c, k) : pval(kind, c, k);
                end else if (extra && c == 0 && k >= nrow) begin
                    en_in[c]   = 1'b1;
                    psum_in[c] = 32'd555;
                end else begin
                    en_in[c]   = 1'b0;
                    psum_in[c] = '0;
                end
            end
            step();
            rd_en = 1'b0;
        end
        en_in = '0;
        for (int c = 0; c < SC; c++) psum_in[c] = '0;
    endtask

    task automatic run_tile(input int base, input int nrow, input int mode, input int kind,
                            input bit extra, input bit rdw);
        int p0;
        p0 = done_pulses;
        do_start(base, nrow, mode);
        check_val("busy_after_start", busy, 1);
        drive(base, nrow, mode, kind, nrow + SC - 1, extra, rdw);
        check_val("wr_done", wr_done, 1);
        step();
        check_val("wr_done_clear", wr_done, 0);
        check_val("busy_idle", busy, 0);
        check_val("wr_done_pulses", done_pulses - p0, 1);
    endtask

    task automatic drain(input int a);
        rd_en   = 1'b1;
        rd_addr = AW'(a);
        sb_q.push_back(pack_row(a));
        step();
        check_val("rd_valid", rd_valid, 1);
        rd_en = 1'b0;
    endtask

    task automatic drain_end();
        step();
        check_val("rd_valid_low", rd_valid, 0);
    endtask

    initial begin
        int p0;
        rstn = 1'b0; start = 1'b0; base_addr = '0; num_row = '0; accum_mode = 1'b0;
        en_in = '0; rd_en = 1'b0; rd_addr = '0;
        for (int c = 0; c < SC; c++) psum_in[c] = '0;
        for (int c = 0; c < SC; c++)
            for (int a = 0; a < AS; a++) model[c][a] = '0;
        step();
        step();
        check_val("rst_busy", busy, 0);
        check_val("rst_wr_done", wr_done, 0);
        check_val("rst_rd_valid", rd_valid, 0);
        check_val("rst_rd_data", rd_data[0], 0);
        rstn = 1'b1;
        step();

        // Overwrite tile
        run_tile(0, 4, 0, 0, 1'b0, 1'b0);
        for (int a = 0; a < 4; a++) drain(a);
        drain_end();

        // Accumulate, with a same-edge read of row 0 returning the old value
        run_tile(0, 4, 1, 0, 1'b0, 1'b1);
        for (int a = 0; a < 4; a++) drain(a);
        drain_end();

        // Wrap-around and modulo overflow
        run_tile(1022, 4, 0, 2, 1'b0, 1'b0);
        run_tile(1022, 4, 1, 1, 1'b0, 1'b0);
        drain(1022); drain(1023); drain(0); drain(1);
        drain_end();
        check_val("wrap_value", rd_data[3], 32'h0000_0001);

        // num_row = 0
        p0 = done_pulses;
        do_start(200, 0, 0);
        check_val("zero_row_wr_done", wr_done, 1);
        step();
        check_val("zero_row_wr_done_clear", wr_done, 0);
        check_val("zero_row_busy", busy, 0);
        check_val("zero_row_pulses", done_pulses - p0, 1);
        drain(1022);
        drain_end();

        // Extra en_in after column done, then en_in in IDLE
        run_tile(0, 4, 0, 0, 1'b1, 1'b0);
        en_in = '1;
        for (int c = 0; c < SC; c++) psum_in[c] = 32'd777;
        step(); step(); step();
        en_in = '0;
        check_val("idle_en_busy", busy, 0);
        for (int a = 0; a < 4; a++) drain(a);
        drain_end();

        // Restart mid-tile
        run_tile(50, 4, 0, 1, 1'b0, 1'b0);
        p0 = done_pulses;
        do_start(50, 4, 0);
        drive(50, 4, 0, 0, 2, 1'b0, 1'b0);
        check_val("restart_busy_pre", busy, 1);
        run_tile(100, 4, 0, 0, 1'b0, 1'b0);
        check_val("restart_total_pulses", done_pulses - p0, 1);
        drain(50); drain(51);
        for (int a = 100; a < 104; a++) drain(a);
        drain_end();

        // Asynchronous reset mid-tile
        do_start(300, 4, 0);
        drive(300, 4, 0, 0, 2, 1'b0, 1'b0);
        rd_en = 1'b1;
        rd_addr = '0;
        step();
        rd_en = 1'b0;
        check_val("rst_mid_busy_pre", busy, 1);
        check_val("rst_mid_rd_valid_pre", rd_valid, 1);
        rstn = 1'b0;
        #1;
        check_val("rst_mid_busy", busy, 0);
        check_val("rst_mid_wr_done", wr_done, 0);
        check_val("rst_mid_rd_valid", rd_valid, 0);
        step();
        rstn = 1'b1;
        step();
        run_tile(0, 4, 1, 0, 1'b0, 1'b0);
        for (int a = 0; a < 4; a++) drain(a);
        drain_end();

        for (int i = 0; i < 20 && sb_q.size() != 0; i++) step();
        check_val("scoreboard_empty", sb_q.size(), 0);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
        $finish;
    end

endmodule
